decode_issue: RTL

- Decode/issue stage that produces the control and operand bundle consumed by the execute ALU (opcode, funct3, funct7[5] bit, operand A, operand B).
- Accepts RV32I instruction words from fetch over a valid/ready handshake.
- Reads a 32-entry register file held inside the block, with writeback bypass, and builds immediates.
- Presents one registered, ALU-ready bundle to execute over a valid/ready handshake, with flush support.

---
 rtl/decode_issue.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - RV32I decode/issue stage with register file, bypass and registered ALU bundle
module decode_issue #(
    parameter bit RF_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        if_vld,
    output logic        if_rdy,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_vld,
    input  logic        ex_rdy,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_pc,
    output logic        ex_illegal
);
    localparam logic [6:0] OP_RR  = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    logic [31:0] r_rf [0:31];

    logic        r_vld;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_funct7;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rd;
    logic [31:0] r_pc;
    logic        r_illegal;

    logic [6:0]  w_op;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_imm;
    logic [2:0]  w_funct3;
    logic        w_funct7;
    logic [4:0]  w_rd;
    logic        w_illegal;
    logic        w_if_rdy;
    logic        w_cap;

    assign w_op  = if_instr[6:0];
    assign w_rs1 = if_instr[19:15];
    assign w_rs2 = if_instr[24:20];

    // Write-first bypass so an instruction sees the value retiring in the same cycle
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                       (wb_en && wb_rd == w_rs1) ? wb_data : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 :
                       (wb_en && wb_rd == w_rs2) ? wb_data : r_rf[w_rs2];

    assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign w_imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign w_imm_u = {if_instr[31:12], 12'd0};
    assign w_imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

    always_comb begin
        w_a       = 32'd0;
        w_b       = 32'd0;
        w_imm     = 32'd0;
        w_funct3  = 3'd0;
        w_funct7  = 1'b0;
        w_rd      = 5'd0;
        w_illegal = 1'b0;
        case (w_op)
            OP_RR: begin
                w_a = w_rs1_val; w_b = w_rs2_val;
                w_funct3 = if_instr[14:12]; w_funct7 = if_instr[30]; w_rd = if_instr[11:7];
            end
            BRANCH: begin
                w_a = w_rs1_val; w_b = w_rs2_val; w_imm = w_imm_b;
                w_funct3 = if_instr[14:12];
            end
            OP_IMM: begin
                w_a = w_rs1_val; w_b = w_imm_i; w_imm = w_imm_i;
                w_funct3 = if_instr[14:12]; w_rd = if_instr[11:7];
                // instr[30] is only an opcode modifier for SRLI/SRAI; elsewhere it is immediate
                w_funct7 = (if_instr[14:12] == 3'b101) && if_instr[30];
            end
            LOAD: begin
                w_a = w_rs1_val; w_b = w_imm_i; w_imm = w_imm_i;
                w_funct3 = if_instr[14:12]; w_rd = if_instr[11:7];
            end
            STORE: begin
                w_a = w_rs1_val; w_b = w_imm_s; w_imm = w_imm_s;
                w_funct3 = if_instr[14:12];
            end
            LUI: begin
                w_b = w_imm_u; w_imm = w_imm_u; w_rd = if_instr[11:7];
            end
            AUIPC: begin
                w_a = if_pc; w_b = w_imm_u; w_imm = w_imm_u; w_rd = if_instr[11:7];
            end
            JAL: begin
                w_a = if_pc; w_b = w_imm_j; w_imm = w_imm_j; w_rd = if_instr[11:7];
            end
            JALR: begin
                w_a = w_rs1_val; w_b = w_imm_i; w_imm = w_imm_i; w_rd = if_instr[11:7];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_if_rdy = !flush && (!r_vld || ex_rdy);
    assign w_cap    = if_vld && w_if_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (RF_RST) r_rf <= '{default: 32'd0};
        end else if (wb_en && wb_rd != 5'd0) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld      <= 1'b0;
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7   <= 1'b0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_rs2_data <= 32'd0;
            r_imm      <= 32'd0;
            r_rd       <= 5'd0;
            r_pc       <= 32'd0;
            r_illegal  <= 1'b0;
        end else begin
            if (flush)              r_vld <= 1'b0;
            else if (w_cap)         r_vld <= 1'b1;
            else if (r_vld && ex_rdy) r_vld <= 1'b0;
            if (w_cap) begin
                r_opcode   <= w_op;
                r_funct3   <= w_funct3;
                r_funct7   <= w_funct7;
                r_a        <= w_a;
                r_b        <= w_b;
                r_rs2_data <= w_rs2_val;
                r_imm      <= w_imm;
                r_rd       <= w_rd;
                r_pc       <= if_pc;
                r_illegal  <= w_illegal;
            end
        end
    end

    assign if_rdy      = w_if_rdy;
    assign ex_vld      = r_vld;
    assign ex_opcode   = r_opcode;
    assign ex_funct3   = r_funct3;
    assign ex_funct7   = r_funct7;
    assign ex_a        = r_a;
    assign ex_b        = r_b;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_rd       = r_rd;
    assign ex_pc       = r_pc;
    assign ex_illegal  = r_illegal;
endmodule
